prog_mem: RTL and testbench
===========================

Name: prog_mem

Overview:
Parametrised, synchronous program memory for the mini CPU. It replaces the fixed combinational instruction table with a writable array. A byte-stream loader port (UART/debug side) fills the array sequentially. The CPU fetch port has a one-cycle registered read with a valid strobe. While a load is in progress, fetch is blocked.

Parameters:
WIDTH, 16, instruction word width in bits; must be a multiple of 8 and at least 8
DEPTH, 256, number of words; must be at least 2
AW, $clog2(DEPTH), derived address width; not to be overridden
BYTES, WIDTH/8, derived bytes per word; not to be overridden

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
fetch_req  input  1  CPU read request for fetch_addr
fetch_addr  input  AW  CPU word address
fetch_data  output  WIDTH  registered read data
fetch_valid  output  1  one-cycle pulse; fetch_data is valid for the request of the previous cycle
load_start  input  1  begin (or restart) a load at word 0
load_byte_valid  input  1  load_byte is presented this cycle
load_byte  input  8  loader data; the first byte of each word is its MS byte
load_done  input  1  end of load stream
load_busy  output  1  high while in LOAD
load_count  output  AW+1  words written by the current/last load
load_err  output  1  sticky overflow flag

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - fetch_data=0, fetch_valid=0, load_busy=0, load_count=0, load_err=0.
  - Write pointer, byte counter and assembly register are cleared.
  - The memory array is NOT cleared; previously written words survive. Contents are undefined at power-up until loaded.
- FSM states: IDLE, LOAD. load_busy = (state==LOAD).
- IDLE -> LOAD on load_start. Same edge: ptr=0, bytecnt=0, load_count=0, load_err=0.
- LOAD -> LOAD on load_start (restart): same clears as above; any pending partial word is discarded.
- LOAD -> IDLE on load_done (and no load_start).
- Fetch:
  - Serviced only in IDLE with no load_start in the same cycle.
  - fetch_req at edge N -> fetch_data=mem[fetch_addr] and fetch_valid=1 after edge N+1. Latency is 1 cycle.
  - Back-to-back requests are accepted every cycle.
  - Without a serviced request: fetch_valid=0 and fetch_data holds its last value.
  - Requests in LOAD, or in the cycle load_start is asserted, are dropped (no valid pulse); the CPU must retry.
- Byte assembly (LOAD only):
  - On load_byte_valid: asm = {asm[WIDTH-9:0], load_byte} and bytecnt++.
  - When the byte completes a word (bytecnt==BYTES-1):
    - If ptr<DEPTH: write mem[ptr] with the full word, then ptr++ and load_count++.
    - Else: drop the word, set load_err=1 (sticky until the next load_start or rst), and leave mem and load_count unchanged.
  - bytecnt wraps to 0 after each completed word.
  - load_byte_valid is ignored in IDLE.
- load_done with a partial word pending (k bytes, 0<k<BYTES): write the word left-aligned and zero-padded, i.e. asm shifted left by 8*(BYTES-k). The overflow rule applies; load_count increments if written.
- load_byte_valid and load_done in the same cycle: the byte is included first, then done is processed on that same edge. The flush word therefore contains that byte.
- load_start and load_done in the same cycle: load_start wins.
- load_count saturates naturally at DEPTH. It holds after LOAD->IDLE until the next load_start.
- Reset mid-load: immediate return to IDLE with counters cleared. Words already written remain readable.
- No read-during-write hazard: fetch and load are mutually exclusive by state.

Test Plan:
1. Default params. Load bytes 13,00,10,03, then load_done → load_count=2, busy falls. Fetch addr 0 → next cycle data 0x1300, valid=1. Fetch addr 1 → 0x1003.
2. Back-to-back fetch of addr 0,1,0 on consecutive cycles → valid high 3 cycles with data 1300,1003,1300, each one cycle after its request. A single request yields exactly one valid pulse.
3. Start load, assert fetch_req during LOAD → fetch_valid stays 0. fetch_req in the load_start cycle is also dropped.
4. Partial flush: byte AB with load_byte_valid and load_done in the same cycle → mem[0]=0xAB00, load_count=1, IDLE next cycle.
5. Overflow, DEPTH=4: 10 bytes → load_count=4, load_err=1, mem[0..3] equal the first four words. A new load_start clears load_err.
6. Reset mid-load after 3 words (default params) → busy=0, load_count=0, load_err=0. Fetch addr 2 returns the third loaded word.

Source files
------------

// File: rtl/prog_mem.sv
// Writable program memory for the mini CPU: a byte-stream loader fills words
// sequentially, and the CPU reads through a one-cycle registered fetch port.
module prog_mem #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int BYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [AW-1:0]    fetch_addr,
  output logic [WIDTH-1:0] fetch_data,
  output logic             fetch_valid,
  input  logic             load_start,
  input  logic             load_byte_valid,
  input  logic [7:0]       load_byte,
  input  logic             load_done,
  output logic             load_busy,
  output logic [AW:0]      load_count,
  output logic             load_err
);

  localparam int BCW = $clog2(BYTES + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      ptr;
  logic [BCW-1:0]   bytecnt;
  logic [BCW-1:0]   cnt_n;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] asm_n;
  logic [WIDTH-1:0] wr_word;
  logic             in_load;
  logic             byte_in;
  logic             word_full;
  logic             flush;
  logic             wr_req;
  logic             wr_ok;

  // The incoming byte is folded in first, so a done in the same cycle
  // flushes a word that already contains it. Older bytes left in the upper
  // part of the assembly register are shifted out by the left-alignment.
  always_comb begin
    in_load   = (state == LOAD) && !load_start;
    byte_in   = in_load && load_byte_valid;
    asm_n     = byte_in ? WIDTH'({asm_q, load_byte}) : asm_q;
    cnt_n     = byte_in ? bytecnt + 1'b1 : bytecnt;
    word_full = byte_in && (cnt_n == BCW'(BYTES));
    flush     = in_load && load_done && !word_full && (cnt_n != '0);
    wr_req    = word_full || flush;
    wr_word   = word_full ? asm_n : asm_n << (8 * (BYTES - int'(cnt_n)));
    wr_ok     = wr_req && (ptr < (AW+1)'(DEPTH));
  end

  // The array has no reset so that loaded code survives a CPU reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      bytecnt     <= '0;
      asm_q       <= '0;
      load_err    <= 1'b0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD;
            ptr      <= '0;
            bytecnt  <= '0;
            asm_q    <= '0;
            load_err <= 1'b0;
          end else if (fetch_req) begin
            fetch_data  <= mem[fetch_addr];
            fetch_valid <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            ptr      <= '0;
            bytecnt  <= '0;
            asm_q    <= '0;
            load_err <= 1'b0;
          end else begin
            if (wr_ok)       ptr      <= ptr + 1'b1;
            else if (wr_req) load_err <= 1'b1;
            if (load_done) begin
              state   <= IDLE;
              bytecnt <= '0;
              asm_q   <= '0;
            end else begin
              bytecnt <= word_full ? '0 : cnt_n;
              asm_q   <= asm_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_busy  = (state == LOAD);
  assign load_count = ptr;

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: a default instance and a DEPTH=4 instance share one
// stimulus stream and are compared every cycle against a byte-queue model.
module tb_prog_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        load_start;
  logic        load_byte_valid;
  logic [7:0]  load_byte;
  logic        load_done;

  logic [15:0] fd_a, fd_b;
  logic        fv_a, fv_b;
  logic        busy_a, busy_b;
  logic [8:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic        err_a, err_b;

  always #5 clk = ~clk;

  prog_mem dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fd_a), .fetch_valid(fv_a),
    .load_start(load_start), .load_byte_valid(load_byte_valid),
    .load_byte(load_byte), .load_done(load_done),
    .load_busy(busy_a), .load_count(cnt_a), .load_err(err_a)
  );

  prog_mem #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr[1:0]),
    .fetch_data(fd_b), .fetch_valid(fv_b),
    .load_start(load_start), .load_byte_valid(load_byte_valid),
    .load_byte(load_byte), .load_done(load_done),
    .load_busy(busy_b), .load_count(cnt_b), .load_err(err_b)
  );

  // Reference model: bytes collect in a queue until a word is complete.
  bit          mBusy;
  logic [7:0]  pend[$];
  int          mCount[2];
  bit          mErr[2];
  logic [15:0] mMem[2][256];
  bit          mKnown[2][256];
  bit          mValid[2];
  logic [15:0] mData[2];
  bit          mDataKnown[2];
  int          depthOf[2] = '{256, 4};

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic void commitWord(input logic [15:0] w);
    for (int i = 0; i < 2; i++) begin
      if (mCount[i] < depthOf[i]) begin
        mMem[i][mCount[i]]   = w;
        mKnown[i][mCount[i]] = 1'b1;
        mCount[i]++;
      end else begin
        mErr[i] = 1'b1;
      end
    end
  endfunction

  function automatic void clearLoad();
    for (int i = 0; i < 2; i++) begin
      mCount[i] = 0;
      mErr[i]   = 1'b0;
    end
    pend.delete();
  endfunction

  function automatic void modelEdge();
    mValid[0] = 1'b0;
    mValid[1] = 1'b0;
    if (!mBusy) begin
      if (load_start) begin
        mBusy = 1'b1;
        clearLoad();
      end else if (fetch_req) begin
        for (int i = 0; i < 2; i++) begin
          int idx;
          idx = (i == 0) ? int'(fetch_addr) : int'(fetch_addr) % 4;
          mValid[i]     = 1'b1;
          mData[i]      = mMem[i][idx];
          mDataKnown[i] = mKnown[i][idx];
        end
      end
    end else if (load_start) begin
      clearLoad();
    end else begin
      if (load_byte_valid) begin
        pend.push_back(load_byte);
        if (pend.size() == 2) begin
          commitWord({pend[0], pend[1]});
          pend.delete();
        end
      end
      if (load_done) begin
        if (pend.size() > 0) commitWord({pend[0], 8'h00});
        pend.delete();
        mBusy = 1'b0;
      end
    end
  endfunction

  function automatic void modelReset();
    mBusy = 1'b0;
    clearLoad();
    for (int i = 0; i < 2; i++) begin
      mValid[i]     = 1'b0;
      mData[i]      = 16'h0000;
      mDataKnown[i] = 1'b1;
    end
  endfunction

  task automatic checkAll();
    checkOutput("busy_a",  32'(busy_a), 32'(mBusy));
    checkOutput("busy_b",  32'(busy_b), 32'(mBusy));
    checkOutput("count_a", 32'(cnt_a),  32'(mCount[0]));
    checkOutput("count_b", 32'(cnt_b),  32'(mCount[1]));
    checkOutput("err_a",   32'(err_a),  32'(mErr[0]));
    checkOutput("err_b",   32'(err_b),  32'(mErr[1]));
    checkOutput("valid_a", 32'(fv_a),   32'(mValid[0]));
    checkOutput("valid_b", 32'(fv_b),   32'(mValid[1]));
    if (mDataKnown[0]) checkOutput("data_a", 32'(fd_a), 32'(mData[0]));
    if (mDataKnown[1]) checkOutput("data_b", 32'(fd_b), 32'(mData[1]));
  endtask

  task automatic applyStimulus(input bit ls, input bit lbv, input logic [7:0] lb,
                               input bit ld, input bit fr, input logic [7:0] fa);
    load_start      = ls;
    load_byte_valid = lbv;
    load_byte       = lb;
    load_done       = ld;
    fetch_req       = fr;
    fetch_addr      = fa;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll();
  endtask

  task automatic loadByte(input logic [7:0] b);
    applyStimulus(0, 1, b, 0, 0, 0);
  endtask

  task automatic fetch(input logic [7:0] a);
    applyStimulus(0, 0, 0, 0, 1, a);
  endtask

  initial begin
    load_start = 0; load_byte_valid = 0; load_byte = 0; load_done = 0;
    fetch_req = 0; fetch_addr = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) mKnown[i][j] = 1'b0;
    doReset();

    // Two-word load then single and back-to-back fetches
    applyStimulus(1, 0, 0, 0, 0, 0);
    loadByte(8'h13); loadByte(8'h00); loadByte(8'h10); loadByte(8'h03);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("p1_count", 32'(cnt_a), 32'd2);
    checkOutput("p1_busy",  32'(busy_a), 32'd0);
    fetch(0);
    checkOutput("p1_d0", 32'(fd_a), 32'h1300);
    checkOutput("p1_v0", 32'(fv_a), 32'd1);
    fetch(1);
    checkOutput("p1_d1", 32'(fd_a), 32'h1003);
    fetch(0); fetch(1); fetch(0);
    checkOutput("p2_d2", 32'(fd_a), 32'h1300);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("p2_pulse", 32'(fv_a), 32'd0);

    // Fetches dropped in the load_start cycle and during LOAD; partial flush
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("p3_start_drop", 32'(fv_a), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("p3_load_drop", 32'(fv_a), 32'd0);
    applyStimulus(0, 1, 8'hAB, 1, 0, 0);
    checkOutput("p4_count", 32'(cnt_a), 32'd1);
    checkOutput("p4_busy",  32'(busy_a), 32'd0);
    fetch(0);
    checkOutput("p4_data", 32'(fd_a), 32'hAB00);

    // Overflow of the DEPTH=4 instance, then a restart clears the error
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) loadByte(8'(8'h20 + i));
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("p5_count_b", 32'(cnt_b), 32'd4);
    checkOutput("p5_err_b",   32'(err_b), 32'd1);
    checkOutput("p5_count_a", 32'(cnt_a), 32'd5);
    for (int i = 0; i < 4; i++) fetch(8'(i));
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("p5_err_clr", 32'(err_b), 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Reset in the middle of a load keeps already written words
    applyStimulus(1, 0, 0, 0, 0, 0);
    loadByte(8'h11); loadByte(8'h22); loadByte(8'h33);
    loadByte(8'h44); loadByte(8'h55); loadByte(8'h66);
    doReset();
    checkOutput("p6_busy", 32'(busy_a), 32'd0);
    fetch(2);
    checkOutput("p6_data", 32'(fd_a), 32'h5566);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        doReset();
      end else if (!mBusy) begin
        applyStimulus($urandom_range(9) == 0, 1'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom), 8'($urandom_range(7)));
      end else begin
        applyStimulus($urandom_range(29) == 0, $urandom_range(9) < 7, 8'($urandom),
                      $urandom_range(9) == 0, $urandom_range(2) == 0,
                      8'($urandom_range(7)));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
